// File: rtl/reg_file_mp.sv
// Multi-read-port register file with register 0 hardwired to zero, optional
// write-to-read forwarding and a sequential bulk-clear FSM that also runs after reset.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NRD        = 2,
    parameter int BYPASS     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [NRD*ADDR_WIDTH-1:0]  raddr,
    output logic [NRD*DATA_WIDTH-1:0]  rdata,
    input  logic                       clr,
    output logic                       ready,
    output logic                       wr_drop
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic                    wr_drop_q;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    logic wr_attempt;
    logic wr_fire;

    // A simultaneous clr takes priority over the write, so it never fires.
    always_comb begin
        wr_attempt = wen && (waddr != '0);
        wr_fire    = ready && wr_attempt && !clr;
    end

    assign ready   = (state_q == IDLE);
    assign wr_drop = wr_drop_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            ptr_q     <= PTR_ONE;
            wr_drop_q <= 1'b0;
        end else begin
            if (wr_attempt && !wr_fire) begin
                wr_drop_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        ptr_q   <= PTR_ONE;
                    end
                end
                CLEAR: begin
                    // Leave on the last entry with ptr parked, so it never wraps.
                    if (ptr_q == PTR_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        ptr_q <= ptr_q + PTR_ONE;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // NOTE: the storage array has no reset term; the clear sequence that
    // follows every reset zeroes it, and reads are masked until it finishes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[ptr_q] <= '0;
            end else if (wr_fire) begin
                regs_q[waddr] <= wdata;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        always_comb begin
            ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd = '0;
            if (ready && (ra != '0)) begin
                if ((BYPASS != 0) && wr_fire && (waddr == ra)) begin
                    rd = wdata;
                end else begin
                    rd = regs_q[ra];
                end
            end
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one forwarding and one non-forwarding
// instance share stimulus; each scenario task checks its own expectations.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wen = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [DW-1:0]    wdata = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic             clr = 1'b0;
    logic [NR*DW-1:0] rdata, rdata_nb;
    logic             ready, ready_nb, wr_drop, wr_drop_nb;

    int tests_run    = 0;
    int tests_failed = 0;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NRD(NR), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .clr(clr), .ready(ready), .wr_drop(wr_drop)
    );

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NRD(NR), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .clr(clr), .ready(ready_nb), .wr_drop(wr_drop_nb)
    );

    always #5 clk = ~clk;

    wire [DW-1:0] rd0    = rdata[DW-1:0];
    wire [DW-1:0] rd1    = rdata[2*DW-1:DW];
    wire [DW-1:0] rd0_nb = rdata_nb[DW-1:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        step();
        wen   = 1'b0;
    endtask

    // Counts rising edges until ready is seen; -1 when the budget runs out.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 100 && ready !== 1'b1) begin
            step();
            n++;
        end
        if (ready !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        wen = 1'b1; waddr = 5'd4; wdata = 32'hFFFF_FFFF;
        step();
        set_raddr(5'd5, 5'd4);
        tests_run++;
        if (ready !== 1'b0 || rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: ready=%b rdata=%h, expected ready=0 rdata=0", ready, rdata);
        end
        step();
        rst = 1'b0;
        wen = 1'b0;
        wait_ready(n);
        tests_run++;
        if (n !== 31) begin
            tests_failed++;
            $display("FAIL reset_clear_len: %0d cycles, expected 31", n);
        end
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wr_drop: got %b, expected 0", wr_drop);
        end
        for (int a = 0; a < 32; a++) begin
            set_raddr(AW'(a), AW'(31 - a));
            tests_run++;
            if (rd0 !== '0 || rd1 !== '0) begin
                tests_failed++;
                $display("FAIL reset_zero[%0d]: p0=%h p1=%h, expected 0", a, rd0, rd1);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEAD_BEEF);
        set_raddr(5'd5, 5'd5);
        tests_run++;
        if (rd0 !== 32'hDEAD_BEEF || rd1 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL write_read_r5: p0=%h p1=%h, expected deadbeef", rd0, rd1);
        end
        do_write(5'd0, 32'h0000_1234);
        set_raddr(5'd0, 5'd5);
        tests_run++;
        if (rd0 !== '0 || rd1 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL write_r0: p0=%h p1=%h, expected 0 / deadbeef", rd0, rd1);
        end
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL r0_no_drop: wr_drop=%b, expected 0", wr_drop);
        end
    endtask

    task automatic test_back_to_back();
        do_write(5'd10, 32'h1010_1010);
        do_write(5'd11, 32'h1111_1111);
        do_write(5'd10, 32'hCAFE_0010);
        set_raddr(5'd10, 5'd11);
        tests_run++;
        if (rd0 !== 32'hCAFE_0010 || rd1 !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL back_to_back: p0=%h p1=%h, expected cafe0010 / 11111111", rd0, rd1);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h7777_7777);
        do_write(5'd8, 32'h8888_8888);
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
        set_raddr(5'd7, 5'd8);
        tests_run++;
        if (rd0 !== 32'hA5A5_A5A5 || rd1 !== 32'h8888_8888) begin
            tests_failed++;
            $display("FAIL bypass_on: p0=%h p1=%h, expected a5a5a5a5 / 88888888", rd0, rd1);
        end
        tests_run++;
        if (rd0_nb !== 32'h7777_7777) begin
            tests_failed++;
            $display("FAIL bypass_off: p0=%h, expected 77777777", rd0_nb);
        end
        step();
        wen = 1'b1; waddr = 5'd8; wdata = 32'h5A5A_5A5A;
        set_raddr(5'd8, 5'd8);
        tests_run++;
        if (rd0 !== 32'h5A5A_5A5A || rd1 !== 32'h5A5A_5A5A) begin
            tests_failed++;
            $display("FAIL bypass_both: p0=%h p1=%h, expected 5a5a5a5a", rd0, rd1);
        end
        step();
        wen = 1'b0;
        set_raddr(5'd7, 5'd8);
        tests_run++;
        if (rd0 !== 32'hA5A5_A5A5 || rd1 !== 32'h5A5A_5A5A || rd0_nb !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL bypass_commit: p0=%h p1=%h nb=%h, expected a5a5a5a5 / 5a5a5a5a / a5a5a5a5",
                     rd0, rd1, rd0_nb);
        end
    endtask

    task automatic test_clear_drop();
        int n;
        do_write(5'd3, 32'h3333_3333);
        do_write(5'd20, 32'h2020_2020);
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_raddr(5'd20, 5'd3);
        tests_run++;
        if (ready !== 1'b0 || rd0 !== '0 || rd1 !== '0) begin
            tests_failed++;
            $display("FAIL clear_masked: ready=%b p0=%h p1=%h, expected 0", ready, rd0, rd1);
        end
        do_write(5'd3, 32'h0BAD_0003);
        tests_run++;
        if (wr_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_drop: wr_drop=%b, expected 1", wr_drop);
        end
        wait_ready(n);
        tests_run++;
        if (n !== 30) begin
            tests_failed++;
            $display("FAIL clear_len: %0d more cycles, expected 30", n);
        end
        set_raddr(5'd3, 5'd20);
        tests_run++;
        if (rd0 !== '0 || rd1 !== '0) begin
            tests_failed++;
            $display("FAIL clear_zero: r3=%h r20=%h, expected 0", rd0, rd1);
        end
        set_raddr(5'd5, 5'd31);
        tests_run++;
        if (rd0 !== '0 || rd1 !== '0) begin
            tests_failed++;
            $display("FAIL clear_zero_edge: r5=%h r31=%h, expected 0", rd0, rd1);
        end
        do_write(5'd31, 32'h3131_3131);
        set_raddr(5'd31, 5'd0);
        tests_run++;
        if (rd0 !== 32'h3131_3131 || wr_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_sticky: r31=%h wr_drop=%b, expected 31313131 / 1", rd0, wr_drop);
        end
    endtask

    task automatic test_clr_write_same();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        tests_run++;
        if (n !== 31 || wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_clears_drop: cycles=%0d wr_drop=%b, expected 31 / 0", n, wr_drop);
        end
        do_write(5'd9, 32'h9999_9999);
        clr = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'hABAB_ABAB;
        set_raddr(5'd9, 5'd0);
        tests_run++;
        if (rd0 !== 32'h9999_9999) begin
            tests_failed++;
            $display("FAIL clr_no_bypass: p0=%h, expected 99999999", rd0);
        end
        step();
        clr = 1'b0; wen = 1'b0;
        tests_run++;
        if (ready !== 1'b0 || wr_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_wins: ready=%b wr_drop=%b, expected 0 / 1", ready, wr_drop);
        end
        wait_ready(n);
        set_raddr(5'd9, 5'd0);
        tests_run++;
        if (n !== 31 || rd0 !== '0) begin
            tests_failed++;
            $display("FAIL clr_wins_after: cycles=%0d r9=%h, expected 31 / 0", n, rd0);
        end
    endtask

    task automatic test_rst_mid_clear();
        int n;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        wen = 1'b1; waddr = 5'd12; wdata = 32'h1212_1212;
        step();
        rst = 1'b0;
        wen = 1'b0;
        tests_run++;
        if (wr_drop !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: wr_drop=%b ready=%b, expected 0 / 0", wr_drop, ready);
        end
        n = 0;
        while (n < 100 && ready !== 1'b1) begin
            clr = (n == 5);
            step();
            n++;
        end
        clr = 1'b0;
        tests_run++;
        if (ready !== 1'b1 || n !== 31) begin
            tests_failed++;
            $display("FAIL rst_mid_len: %0d cycles ready=%b, expected 31 / 1", n, ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_bypass();
        test_clear_drop();
        test_clr_write_same();
        test_rst_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the register data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the address width; DEPTH = 2^ADDR_WIDTH registers.
REQ-003 Parameter NRD, default 2, sets the number of read ports, with range 1..8.
REQ-004 Parameter BYPASS, default 1; a value of 1 enables write-to-read forwarding and 0 disables it.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wen  input  1  write enable.
REQ-008 waddr  input  ADDR_WIDTH  write address.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 raddr  input  NRD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 rdata  output  NRD*DATA_WIDTH  read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 clr  input  1  single-cycle request to start a bulk clear of all registers.
REQ-013 ready  output  1  high when the file is in IDLE and accepts writes.
REQ-014 wr_drop  output  1  sticky flag; high when a write was discarded.

Function
REQ-015 The block SHALL have a two-state FSM, IDLE and CLEAR, plus a clear pointer ptr of ADDR_WIDTH bits.
REQ-016 Register 0 SHALL always read as zero and SHALL never be written.
REQ-017 In IDLE, a write with wen=1 and waddr!=0 SHALL update register waddr with wdata at the clock edge.
REQ-018 In IDLE, a write with wen=1 and waddr=0 SHALL be ignored and SHALL NOT set wr_drop.
REQ-019 Reads SHALL be combinational: rdata port i = register[raddr port i], except where REQ-020 through REQ-022 apply.
REQ-020 When BYPASS=1, ready=1, wen=1, waddr!=0 and waddr equals raddr port i, port i SHALL return wdata in the same cycle.
REQ-021 Bypass SHALL be evaluated independently per port; any number of ports may forward simultaneously.
REQ-022 While ready=0, every read port SHALL return zero.
REQ-023 When clr=1 in IDLE, the FSM SHALL enter CLEAR with ptr=1.
REQ-024 clr asserted while in CLEAR SHALL be ignored; the clear sequence is not restarted.
REQ-025 In CLEAR, each cycle SHALL write zero to register[ptr] and increment ptr.
REQ-026 When ptr=DEPTH-1, CLEAR SHALL write that register and return to IDLE at the same edge.
REQ-027 CLEAR SHALL last exactly DEPTH-1 cycles; ready SHALL be 0 throughout CLEAR.
REQ-028 A write attempt (wen=1, waddr!=0) while ready=0 and rst=0 SHALL be discarded and SHALL set wr_drop.
REQ-029 If clr=1 and a valid write occur in the same IDLE cycle, clr SHALL win: the write is discarded, wr_drop is set, and bypass does not apply.
REQ-030 wr_drop SHALL be cleared only by rst.
REQ-031 ptr SHALL NOT wrap; the FSM exits CLEAR before ptr overflows.

Reset
REQ-032 While rst=1, the block SHALL set state to CLEAR, ptr to 1 and wr_drop to 0, and hold ready at 0.
REQ-033 While rst=1, the block SHALL perform no register writes, and writes presented during rst SHALL NOT set wr_drop.
REQ-034 After rst falls, the clear sequence SHALL run per REQ-025 through REQ-027, so ready rises DEPTH-1 cycles later (31 cycles at the defaults).
REQ-035 rst asserted mid-CLEAR SHALL restart the sequence from ptr=1.
REQ-036 rst asserted mid-IDLE SHALL abort any pending write in that cycle.
REQ-037 rdata SHALL read as 0 from the first edge with rst=1 until ready rises.

Verification
REQ-038 Scenario: hold rst for 2 cycles, release, count cycles -> ready=0 for exactly 31 cycles, then 1; all registers read 0; wr_drop=0.
REQ-039 Scenario: write 0xDEADBEEF to register 5, then read via port 0 and port 1 on the next cycle -> both return 0xDEADBEEF; a write of 0x1234 to register 0 still reads 0.
REQ-040 Scenario: BYPASS=1, wen=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7, raddr1=8 -> same cycle port0=0xA5A5A5A5 and port1=old register 8 value; with BYPASS=0, port0 returns the old register 7 value.
REQ-041 Scenario: pulse clr, then write register 3 during the clear -> write discarded, wr_drop=1, register 3 reads 0 after ready rises; wr_drop stays 1 until rst.
REQ-042 Scenario: clr and write to register 9 in the same cycle -> register 9 is not updated, wr_drop=1, ready falls at the next edge.
REQ-043 Scenario: assert rst at the 10th cycle of CLEAR -> the sequence restarts; ready rises 31 cycles after rst falls; a second clr pulse during CLEAR does not extend it.
